// File: rtl/sprite_pkg.sv
// sprite_pkg: screen/sprite geometry, walk state encoding and sprite entry layout
// shared by the motion scheduler and the renderer.
package sprite_pkg;
   localparam int SCR_W = 640;
   localparam int SCR_H = 480;
   localparam int SPR_W = 100;
   localparam int SPR_H = 134;
   localparam int POS_W = 10;
   localparam int VEL_W = 6;
   localparam logic [POS_W-1:0] LIM_X = POS_W'(SCR_W - SPR_W);
   localparam logic [POS_W-1:0] LIM_Y = POS_W'(SCR_H - SPR_H);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_STORE, S_DONE} state_t;
   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic [VEL_W-1:0] vx;
      logic [VEL_W-1:0] vy;
   } spr_t;
   localparam spr_t SPR_RST = '{x: '0, y: '0, vx: VEL_W'(2), vy: VEL_W'(2)};
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis edge bounce; the sum is taken two bits wider so that
// both underflow below 0 and overshoot past LIM are seen without wrapping.
module sprite_axis_step
   import sprite_pkg::*;
(
   input  logic [POS_W-1:0] p,
   input  logic [VEL_W-1:0] v,
   input  logic [POS_W-1:0] lim,
   output logic [POS_W-1:0] p_n,
   output logic [VEL_W-1:0] v_n
);
   logic signed [POS_W+1:0] n;
   logic [VEL_W-1:0] v_neg;
   always_comb begin
      n = $signed({2'b00, p}) + $signed({{(POS_W+2-VEL_W){v[VEL_W-1]}}, v});
      // negating the most-negative velocity saturates instead of wrapping back to itself
      v_neg = (v == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}} : -v;
      p_n = n[POS_W+1] ? '0 : (n > $signed({2'b00, lim})) ? lim : n[POS_W-1:0];
      v_n = (n[POS_W+1] || n > $signed({2'b00, lim})) ? v_neg : v;
   end
endmodule

// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: per-frame walk over the sprite table applying the bounce rule,
// with host configuration writes, renderer read port and animation select.
module sprite_motion_sched
   import sprite_pkg::*;
#(
   parameter int NUM_SPR    = 4,
   parameter int IDX_W      = 2,
   parameter int ANIM_SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             next_frame,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [POS_W-1:0] cfg_x,
   input  logic [POS_W-1:0] cfg_y,
   input  logic [VEL_W-1:0] cfg_vx,
   input  logic [VEL_W-1:0] cfg_vy,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [POS_W-1:0] rd_x,
   output logic [POS_W-1:0] rd_y,
   output logic             busy,
   output logic             frame_done,
   output logic             anim_sel,
   output logic             overrun
);
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   spr_t cur_q, cur_d, res_q, res_d, calc;
   spr_t tbl_q [NUM_SPR];
   spr_t tbl_d [NUM_SPR];
   logic sup_q, sup_d, ovr_q, ovr_d, hit;
   logic [ANIM_SHIFT:0] cnt_q, cnt_d;

   sprite_axis_step u_x (.p(cur_q.x), .v(cur_q.vx), .lim(LIM_X), .p_n(calc.x), .v_n(calc.vx));
   sprite_axis_step u_y (.p(cur_q.y), .v(cur_q.vy), .lim(LIM_Y), .p_n(calc.y), .v_n(calc.vy));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = (state_q == S_IDLE)  ? (next_frame ? S_LOAD : S_IDLE) :
                (state_q == S_LOAD)  ? S_CALC :
                (state_q == S_CALC)  ? S_STORE :
                (state_q == S_STORE) ? ((idx_q == IDX_W'(NUM_SPR-1)) ? S_DONE : S_LOAD) :
                S_IDLE;
   end

   always_comb begin
      busy       = state_q != S_IDLE;
      frame_done = state_q == S_DONE;
      anim_sel   = cnt_q[ANIM_SHIFT];
      overrun    = ovr_q;
      rd_x       = tbl_q[rd_idx].x;
      rd_y       = tbl_q[rd_idx].y;
   end

   always_comb begin
      hit   = cfg_we && (cfg_idx == idx_q);
      idx_d = (state_q == S_STORE) ? idx_q + 1'b1 : (state_q == S_IDLE) ? '0 : idx_q;
      cur_d = (state_q == S_LOAD) ? tbl_q[idx_q] : cur_q;
      res_d = (state_q == S_CALC) ? calc : res_q;
      sup_d = (state_q == S_CALC) ? hit : sup_q;
      cnt_d = (next_frame && state_q == S_IDLE) ? cnt_q + 1'b1 : cnt_q;
      ovr_d = ovr_q || (next_frame && state_q != S_IDLE);
      tbl_d = tbl_q;
      // a host write to the sprite in flight wins over its write-back
      if (state_q == S_STORE && !sup_q && !hit) tbl_d[idx_q] = res_q;
      if (cfg_we) tbl_d[cfg_idx] = '{x: cfg_x, y: cfg_y, vx: cfg_vx, vy: cfg_vy};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         cur_q <= SPR_RST;
         res_q <= SPR_RST;
         sup_q <= 1'b0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
         for (int i = 0; i < NUM_SPR; i++) tbl_q[i] <= SPR_RST;
      end else begin
         idx_q <= idx_d;
         cur_q <= cur_d;
         res_q <= res_d;
         sup_q <= sup_d;
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
         tbl_q <= tbl_d;
      end
   end
endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb_sprite_motion_sched: directed vectors against hand-computed bounce positions,
// walk latency, overrun, host-write priority and animation select.
module tb_sprite_motion_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       next_frame = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [9:0] cfg_x = '0, cfg_y = '0;
   logic [5:0] cfg_vx = '0, cfg_vy = '0;
   logic [1:0] rd_idx = '0;
   logic [9:0] rd_x, rd_y;
   logic       busy, frame_done, anim_sel, overrun;
   int n_tests = 0;
   int n_fail = 0;

   sprite_motion_sched dut (
      .clk(clk), .rst(rst), .next_frame(next_frame), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .rd_idx(rd_idx),
      .rd_x(rd_x), .rd_y(rd_y), .busy(busy), .frame_done(frame_done),
      .anim_sel(anim_sel), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int idx, input int x, input int y, input int vx, input int vy);
      cfg_idx = 2'(idx);
      cfg_x   = 10'(x);
      cfg_y   = 10'(y);
      cfg_vx  = 6'(vx);
      cfg_vy  = 6'(vy);
      cfg_we  = 1'b1;
   endtask

   task automatic cfg(input int idx, input int x, input int y, input int vx, input int vy);
      set_cfg(idx, x, y, vx, vy);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic frame(input string tag);
      int lat;
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      cfg_we = 1'b0;
      lat = 1;
      while (frame_done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, 13);
      tick();
   endtask

   task automatic chk_pos(input string tag, input int idx, input int x, input int y);
      rd_idx = 2'(idx);
      #1;
      check({tag, " x"}, {22'd0, rd_x}, x);
      check({tag, " y"}, {22'd0, rd_y}, y);
   endtask

   initial begin
      int lat;
      int pulses;
      tick();
      tick();
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
      check("reset anim_sel", anim_sel, 0);
      check("reset overrun", overrun, 0);
      chk_pos("reset spr0", 0, 0, 0);
      rst = 1'b1;
      tick();

      frame("t1 f1");
      chk_pos("t1 spr0", 0, 2, 2);
      chk_pos("t1 spr3", 3, 2, 2);
      frame("t1 f2");
      chk_pos("t1 spr0 f2", 0, 4, 4);

      cfg(0, 538, 10, 2, 0);
      frame("t2 a");
      chk_pos("t2 reach lim", 0, 540, 10);
      frame("t2 b");
      chk_pos("t2 bounce", 0, 540, 10);
      frame("t2 c");
      chk_pos("t2 back", 0, 538, 10);
      cfg(0, 539, 10, 2, 0);
      frame("t2 d");
      chk_pos("t2 overshoot", 0, 540, 10);
      frame("t2 e");
      chk_pos("t2 overshoot back", 0, 538, 10);

      cfg(3, 0, 1, 0, -3);
      frame("t3 a");
      chk_pos("t3 below zero", 3, 0, 0);
      frame("t3 b");
      chk_pos("t3 rebound", 3, 0, 3);
      cfg(3, 0, 345, 0, 1);
      frame("t3 c");
      chk_pos("t3 reach limy", 3, 0, 346);
      frame("t3 d");
      chk_pos("t3 bounce limy", 3, 0, 346);
      frame("t3 e");
      chk_pos("t3 back limy", 3, 0, 345);

      cfg(2, 10, 100, -32, 0);
      frame("sat a");
      chk_pos("sat clamp", 2, 0, 100);
      frame("sat b");
      chk_pos("sat vel", 2, 31, 100);

      set_cfg(2, 200, 0, 5, 0);
      frame("same cycle");
      chk_pos("same cycle cfg", 2, 205, 0);

      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      repeat (4) tick();
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      check("t4 overrun", overrun, 1);
      check("t4 busy", busy, 1);
      lat = 6;
      while (frame_done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("t4 latency", lat, 13);
      pulses = 0;
      repeat (20) begin
         tick();
         if (frame_done === 1'b1) pulses++;
      end
      check("t4 no restart", pulses, 0);
      check("t4 idle", busy, 0);

      cfg(1, 300, 60, 1, 1);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      repeat (4) tick();
      set_cfg(1, 100, 50, 0, 0);
      tick();
      cfg_we = 1'b0;
      lat = 6;
      while (frame_done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("t5 latency", lat, 13);
      tick();
      chk_pos("t5 cfg wins", 1, 100, 50);
      frame("t5 next");
      chk_pos("t5 still", 1, 100, 50);

      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) frame("t6 loop");
      check("t6 anim 15", anim_sel, 0);
      frame("t6 16th");
      check("t6 anim 16", anim_sel, 1);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      repeat (2) tick();
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      check("t6 overrun pre", overrun, 1);
      rst = 1'b0;
      #1;
      check("t6 rst busy", busy, 0);
      check("t6 rst frame_done", frame_done, 0);
      check("t6 rst anim", anim_sel, 0);
      check("t6 rst overrun", overrun, 0);
      chk_pos("t6 rst spr0", 0, 0, 0);
      chk_pos("t6 rst spr1", 1, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      check("t6 stays idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
